count_seg7_display: RTL and testbench

- Downstream consumer of the 8-bit free-running counter value `cmpt`.
- Converts the binary count to three BCD digits using a sequential shift-add-3 (double-dabble) FSM.
- Drives a time-multiplexed 3-digit 7-segment display with leading-zero blanking.
- Sits between the counter instance and the top-level output pins: segments on uo_out, digit enables on uio_out.

---
 rtl/count_seg7_display.sv | 156 +++++++++++++++
 tb/tb_count_seg7_display.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/count_seg7_display.sv
// Binary-to-BCD (shift-add-3) converter driving a multiplexed 3-digit
// 7-segment display with leading-zero blanking.
module count_seg7_display #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmpt,
    output logic [6:0]  seg,
    output logic [2:0]  dig_sel,
    output logic [11:0] bcd_out,
    output logic        bcd_valid
);

    localparam int unsigned DIV_W    = 16;
    localparam int unsigned ITER_W   = 3;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [2:0]  DIG_OFF  = {3{DIG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          bin_sr;
    logic [11:0]         bcd_scr;
    logic [ITER_W-1:0]   iter;
    logic [11:0]         bcd_adj_c;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          dig_idx;
    logic [3:0]          nib_c;
    logic                blank_c;
    logic [6:0]          seg_c;
    logic [2:0]          dig_c;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Conversion FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = SHIFT;
            SHIFT:   if (iter == ITER_W'(7)) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj_c = {add3(bcd_scr[11:8]), add3(bcd_scr[7:4]), add3(bcd_scr[3:0])};
    end

    // Conversion datapath; the top scratch bit is dropped since results stay below 256
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr    <= '0;
            bcd_scr   <= '0;
            iter      <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= (state == LOAD);
            case (state)
                IDLE: begin
                    bin_sr  <= cmpt;
                    bcd_scr <= '0;
                    iter    <= '0;
                end
                SHIFT: begin
                    {bcd_scr, bin_sr} <= {bcd_adj_c[10:0], bin_sr, 1'b0};
                    iter              <= iter + ITER_W'(1);
                end
                LOAD:    bcd_out <= bcd_scr;
                default: ;
            endcase
        end
    end

    // Scan divider and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            dig_idx <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        nib_c   = bcd_out[3:0];
        blank_c = 1'b0;
        dig_c   = 3'b001;
        case (dig_idx)
            2'd1: begin
                nib_c   = bcd_out[7:4];
                blank_c = (bcd_out[11:4] == 8'd0);
                dig_c   = 3'b010;
            end
            2'd2: begin
                nib_c   = bcd_out[11:8];
                blank_c = (bcd_out[11:8] == 4'd0);
                dig_c   = 3'b100;
            end
            default: ;
        endcase
        seg_c = decode(nib_c);
        if (blank_c) begin
            seg_c = 7'h00;
            dig_c = 3'b000;
        end
    end

    // Output register with polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            seg     <= SEG_OFF;
            dig_sel <= DIG_OFF;
        end else begin
            seg     <= seg_c ^ SEG_OFF;
            dig_sel <= dig_c ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_count_seg7_display.sv
// Directed self-checking bench for count_seg7_display.
module tb_count_seg7_display;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [7:0]  cmpt, cmpt2;
    logic [6:0]  seg, seg2;
    logic [2:0]  dig_sel, dig2;
    logic [11:0] bcd_out, bcd2;
    logic        bcd_valid, valid2;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    int edge2_n  = 0;

    always #5 clk = ~clk;

    count_seg7_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst(rst), .cmpt(cmpt), .seg(seg), .dig_sel(dig_sel),
        .bcd_out(bcd_out), .bcd_valid(bcd_valid)
    );

    count_seg7_display #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_pol (
        .clk(clk), .rst(rst2), .cmpt(cmpt2), .seg(seg2), .dig_sel(dig2),
        .bcd_out(bcd2), .bcd_valid(valid2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edge counters restart at 0 on every reset edge
    task automatic tick;
        @(posedge clk);
        edge_n  = rst  ? 0 : edge_n + 1;
        edge2_n = rst2 ? 0 : edge2_n + 1;
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    task automatic exp_disp(input logic [11:0] b, input int slot,
                            output logic [6:0] s, output logic [2:0] d);
        logic [3:0] nib;
        logic       blank;
        nib   = (slot == 0) ? b[3:0] : (slot == 1) ? b[7:4] : b[11:8];
        blank = (slot == 2) ? (b[11:8] == 4'd0) :
                (slot == 1) ? (b[11:4] == 8'd0) : 1'b0;
        s = blank ? 7'h00 : seg_of(nib);
        d = blank ? 3'b000 : (3'b001 << slot);
    endtask

    // Output after edge e shows the digit index held before that edge
    task automatic check_scan(input logic [11:0] b, input int n);
        logic [6:0] s;
        logic [2:0] d;
        for (int i = 0; i < n; i++) begin
            tick;
            exp_disp(b, ((edge_n - 1) / 4) % 3, s, d);
            check_eq("scan_dig", dig_sel, d);
            check_eq("scan_seg", seg, s);
        end
    endtask

    task automatic check_scan_pol(input logic [11:0] b, input int n);
        logic [6:0] s, se;
        logic [2:0] d, de;
        for (int i = 0; i < n; i++) begin
            tick;
            exp_disp(b, (edge2_n - 1) % 3, s, d);
            se = ~s;
            de = ~d;
            check_eq("pol_dig", dig2, de);
            check_eq("pol_seg", seg2, se);
        end
    endtask

    task automatic wait_valid;
        int n;
        n = 0;
        do begin
            tick;
            n++;
        end while (!bcd_valid && n < 30);
        check_eq("valid_seen", bcd_valid, 1);
    endtask

    task automatic wait_valid2;
        int n;
        n = 0;
        do begin
            tick;
            n++;
        end while (!valid2 && n < 30);
        check_eq("valid2_seen", valid2, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        rst   = 1'b1;
        rst2  = 1'b1;
        cmpt  = 8'h00;
        cmpt2 = 8'd8;

        // Reset entry
        for (int i = 0; i < 3; i++) begin
            tick;
            check_eq("rst_seg", seg, 7'h00);
            check_eq("rst_dig", dig_sel, 3'b000);
            check_eq("rst_valid", bcd_valid, 1'b0);
            check_eq("rst_bcd", bcd_out, 12'h000);
        end
        check_eq("pol_rst_seg", seg2, 7'h7F);
        check_eq("pol_rst_dig", dig2, 3'b111);

        // Release; first sample of 255 happens on this edge
        rst  = 1'b0;
        cmpt = 8'd255;
        tick;
        check_eq("rel_dig", dig_sel, 3'b001);
        check_eq("rel_seg", seg, 7'h3F);
        for (int i = 2; i <= 9; i++) begin
            tick;
            check_eq("lat_valid_low", bcd_valid, 1'b0);
        end
        tick;
        check_eq("lat_valid", bcd_valid, 1'b1);
        check_eq("full_bcd", bcd_out, 12'h255);
        check_scan(12'h255, 15);

        // Blanking: 7 then 100
        wait_valid;
        cmpt = 8'd7;
        wait_valid;
        check_eq("bcd_7", bcd_out, 12'h007);
        check_scan(12'h007, 12);
        wait_valid;
        cmpt = 8'd100;
        wait_valid;
        check_eq("bcd_100", bcd_out, 12'h100);
        check_scan(12'h100, 12);

        // Input change during SHIFT is ignored until the next sample
        wait_valid;
        cmpt = 8'd42;
        repeat (3) tick;
        cmpt = 8'd99;
        wait_valid;
        check_eq("bcd_42", bcd_out, 12'h042);
        tick;
        check_eq("valid_pulse_end", bcd_valid, 1'b0);
        wait_valid;
        check_eq("bcd_99", bcd_out, 12'h099);

        // Reset in SHIFT cycle 5 while the hundreds digit is shown
        cmpt  = 8'd255;
        found = 0;
        for (int k = 0; k < 6 && found == 0; k++) begin
            wait_valid;
            if (((edge_n + 4) / 4) % 3 == 2) found = 1;
        end
        check_eq("midrst_aligned", found, 1);
        repeat (5) tick;
        check_eq("pre_rst_dig", dig_sel, 3'b100);
        rst = 1'b1;
        tick;
        check_eq("midrst_seg", seg, 7'h00);
        check_eq("midrst_dig", dig_sel, 3'b000);
        check_eq("midrst_bcd", bcd_out, 12'h000);
        check_eq("midrst_valid", bcd_valid, 1'b0);
        rst  = 1'b0;
        cmpt = 8'd123;
        tick;
        check_eq("rel2_dig", dig_sel, 3'b001);
        check_eq("rel2_seg", seg, 7'h3F);
        check_eq("rel2_valid", bcd_valid, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            tick;
            check_eq("rel2_valid_low", bcd_valid, 1'b0);
        end
        tick;
        check_eq("rel2_valid_hi", bcd_valid, 1'b1);
        check_eq("bcd_123", bcd_out, 12'h123);

        // Inverted polarity, scan advancing every cycle
        rst2 = 1'b0;
        wait_valid2;
        check_eq("pol_bcd", bcd2, 12'h008);
        check_scan_pol(12'h008, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
